sfq_pulse_driver: RTL and testbench

Clocked source for toggle-encoded SFQ pulse trains. Each SFQ pulse is one transition of `out`, either rising or falling, which is the encoding the JTL and gate models consume. The block accepts burst commands (pulse count plus spacing) over a valid/ready handshake and emits the train on `out`. It holds off through a start-up window so no edge lands inside the downstream cells' settling time. It sits at the input of every cell-level bench and any chain of SFQ cell models.

---
 rtl/sfq_pulse_driver.sv | 101 ++++++++++
 tb/tb_sfq_pulse_driver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sfq_pulse_driver.sv
// sfq_pulse_driver: toggle-encoded SFQ pulse-train source with start-up holdoff and burst commands
module sfq_pulse_driver #(
  parameter int STARTUP_CYCLES = 8,
  parameter int MIN_GAP = 2,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_count,
  input  logic [CW-1:0] cmd_gap,
  input  logic          abort,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic [15:0]   pulses_sent
);
  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d, gap_q, gap_d, gcnt_q, gcnt_d, gap_eff;
  logic [15:0] pulses_q, pulses_d;
  logic out_q, out_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  assign gap_eff = cmd_gap < CW'(MIN_GAP) ? CW'(MIN_GAP) : cmd_gap;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    gap_d = gap_q;
    gcnt_d = gcnt_q;
    pulses_d = pulses_q;
    out_d = out_q;
    ready_d = ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      INIT: begin
        hold_d = hold_q == 32'd0 ? hold_q : hold_q - 32'd1;
        state_d = hold_q == 32'd0 ? IDLE : INIT;
        ready_d = hold_q == 32'd0;
      end
      IDLE: if (cmd_valid) begin
        cnt_d = cmd_count;
        gap_d = gap_eff;
        gcnt_d = '0;
        done_d = cmd_count == '0;
        state_d = cmd_count == '0 ? IDLE : RUN;
        ready_d = cmd_count == '0;
        busy_d = cmd_count != '0;
      end
      RUN: begin
        // abort wins over a scheduled toggle; cnt_q==0 is the closing edge after the last toggle
        if (abort || cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d = 1'b0;
          done_d = !abort;
        end else if (gcnt_q == '0) begin
          out_d = !out_q;
          pulses_d = pulses_q + 16'd1;
          cnt_d = cnt_q - CW'(1);
          gcnt_d = gap_q - CW'(1);
        end else begin
          gcnt_d = gcnt_q - CW'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      hold_q <= 32'(STARTUP_CYCLES);
      cnt_q <= '0;
      gap_q <= '0;
      gcnt_q <= '0;
      pulses_q <= '0;
      out_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      gcnt_q <= gcnt_d;
      pulses_q <= pulses_d;
      out_q <= out_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign out = out_q;
  assign cmd_ready = ready_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pulses_sent = pulses_q;
endmodule

// File: tb/tb_sfq_pulse_driver.sv
// tb_sfq_pulse_driver: directed + randomized bench against a schedule-based reference model
`timescale 1ps/100fs
module tb_sfq_pulse_driver;
  localparam int S = 8;
  localparam int MG = 2;
  logic clk = 1'b0;
  logic rst_n, cmd_valid, abort, out, cmd_ready, busy, done;
  logic [7:0] cmd_count, cmd_gap;
  logic [15:0] pulses_sent;
  int errors = 0;
  int checks = 0;
  int e = 0;
  int bn, bc, bg;
  logic m_ready, m_busy, m_done, hs;
  logic [15:0] m_pulses;

  sfq_pulse_driver #(.STARTUP_CYCLES(S), .MIN_GAP(MG), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_count(cmd_count), .cmd_gap(cmd_gap), .abort(abort), .out(out),
    .busy(busy), .done(done), .pulses_sent(pulses_sent)
  );

  always #500 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Reference: a burst accepted at edge N with count c and effective gap g toggles at
  // N+1+k*g for k<c and closes at the edge after the last toggle.
  task automatic step(input logic rn, input logic v, input logic [7:0] c, input logic [7:0] g, input logic ab);
    logic pr, pb;
    rst_n = rn; cmd_valid = v; cmd_count = c; cmd_gap = g; abort = ab;
    @(posedge clk);
    hs = 1'b0;
    if (!rn) begin
      e = 0; m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pulses = 16'd0;
    end else begin
      e++;
      pr = m_ready; pb = m_busy; m_done = 1'b0;
      if (!pr && !pb) begin
        if (e == S + 1) m_ready = 1'b1;
      end else if (pr) begin
        if (v) begin
          hs = 1'b1;
          if (c == 8'd0) m_done = 1'b1;
          else begin
            m_ready = 1'b0; m_busy = 1'b1; bn = e; bc = int'(c);
            bg = int'(g) < MG ? MG : int'(g);
          end
        end
      end else if (ab) begin
        m_busy = 1'b0; m_ready = 1'b1;
      end else if (e == bn + 1 + (bc - 1) * bg + 1) begin
        m_busy = 1'b0; m_ready = 1'b1; m_done = 1'b1;
      end else if ((e - bn - 1) % bg == 0) begin
        m_pulses = m_pulses + 16'd1;
      end
    end
    #1;
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("pulses_sent", 32'(pulses_sent), 32'(m_pulses));
    chk("out", 32'(out), 32'(m_pulses[0]));
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    step(1'b0, 1'b1, 8'd3, 8'd1, 1'b1);
  endtask

  task automatic handshake(input logic [7:0] c, input logic [7:0] g);
    int n = 0;
    hs = 1'b0;
    while (!hs && n < 50) begin
      step(1'b1, 1'b1, c, g, 1'b0);
      n++;
    end
    if (!hs) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_burst(input int ab_rel, input logic noise);
    int n = 0;
    while (m_busy && n < 3000) begin
      step(1'b1, noise && $urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom),
           ab_rel != 0 && e + 1 - bn == ab_rel);
      n++;
    end
    if (m_busy) chk("burst_timeout", 32'd0, 32'd1);
  endtask

  task automatic burst(input logic [7:0] c, input logic [7:0] g, input int ab_rel, input logic noise);
    handshake(c, g);
    finish_burst(ab_rel, noise);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_count = '0; cmd_gap = '0;
    do_reset();
    burst(8'd3, 8'd2, 0, 1'b0);
    chk("startup_pulses", 32'(pulses_sent), 32'd3);
    chk("startup_out", 32'(out), 32'd1);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    burst(8'd4, 8'd0, 0, 1'b1);
    burst(8'd2, 8'd5, 0, 1'b1);
    chk("clamp_pulses", 32'(pulses_sent), 32'd9);
    burst(8'd0, 8'd3, 0, 1'b0);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    burst(8'd10, 8'd3, 10, 1'b1);
    chk("abort_pulses", 32'(pulses_sent), 32'd12);
    step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    do_reset();
    handshake(8'd10, 8'd2);
    for (int n = 0; n < 40 && m_pulses != 16'd5; n++) step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("midburst_out", 32'(out), 32'd1);
    step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_pulses", 32'(pulses_sent), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int n = 0; n < 6; n++) begin
      handshake(8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)));
      finish_burst($urandom_range(0, 1) == 1 ? int'($urandom_range(1, 12)) : 0, 1'b1);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
    end
    do_reset();
    for (int n = 0; n < 257; n++) burst(8'd255, 8'd1, 0, 1'b1);
    chk("wrap_pulses", 32'(pulses_sent), 32'd65535);
    burst(8'd1, 8'd1, 0, 1'b0);
    chk("wrap_zero", 32'(pulses_sent), 32'd0);
    chk("wrap_out", 32'(out), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
